// File: rtl/switch_box_config_loader_pkg.sv
// Shared types and helpers for the switch box configuration loader.
// Elaborated once regardless of SWITCH_BOX_CONFIG_LOADER_PARITY_EN; CHECK is simply unused without it.
package switch_box_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Width of a counter addressing n chunks; never narrower than one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TRACK_BITS      = 8;
    localparam int DEFAULT_IN_W    = 8;
    localparam int CHUNK_PER_TRACK = TRACK_BITS / DEFAULT_IN_W;

endpackage

// File: rtl/switch_box_config_loader.sv
// Assembles a CONF_WIDTH-bit switch box frame from IN_W-bit valid/ready chunks and commits it with cset.
// Optional parity chunk check enabled by defining SWITCH_BOX_CONFIG_LOADER_PARITY_EN.
module switch_box_config_loader
    import switch_box_cfg_pkg::*;
#(
    parameter int W          = 8,
    parameter int CONF_WIDTH = 8 * W,
    parameter int IN_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [IN_W-1:0]       cfg_data,
    input  logic                  cfg_start,
    output logic [CONF_WIDTH-1:0] c,
    output logic                  cset,
    output logic                  busy,
    output logic                  err
);

    localparam int NUM_CHUNKS = CONF_WIDTH / IN_W;
    localparam int IW         = index_width(NUM_CHUNKS);

    if ((CONF_WIDTH % IN_W) != 0) begin : g_bad_chunk_width
        $error("CONF_WIDTH must be a multiple of IN_W");
    end

`ifdef SWITCH_BOX_CONFIG_LOADER_PARITY_EN
    localparam state_t LAST_STATE = CHECK;
`else
    localparam state_t LAST_STATE = COMMIT;
`endif

    state_t          state, state_next;
    logic [IW-1:0]   index, index_next;
    logic [IW-1:0]   store_idx;
    logic            store;
    logic            err_next;
    logic            accept;

    assign cfg_ready = (state != COMMIT);
    assign accept    = cfg_valid && cfg_ready;
    assign cset      = (state == COMMIT);
    assign busy      = (state != IDLE);

`ifdef SWITCH_BOX_CONFIG_LOADER_PARITY_EN
    logic parity;
`endif

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        index_next = index;
        err_next   = err;
        store      = 1'b0;
        store_idx  = index;

        if (accept && cfg_start) begin
            // A start chunk always (re)opens a frame, from IDLE, LOAD or CHECK alike.
            store     = 1'b1;
            store_idx = '0;
            if (NUM_CHUNKS == 1) begin
                index_next = '0;
                state_next = LAST_STATE;
            end else begin
                index_next = IW'(1);
                state_next = LOAD;
            end
        end else if (accept) begin
            case (state)
                IDLE: begin
                    err_next = 1'b1;
                end
                LOAD: begin
                    store = 1'b1;
                    if (index == IW'(NUM_CHUNKS - 1)) begin
                        index_next = '0;
                        state_next = LAST_STATE;
                    end else begin
                        index_next = index + IW'(1);
                    end
                end
`ifdef SWITCH_BOX_CONFIG_LOADER_PARITY_EN
                CHECK: begin
                    if (cfg_data[0] == parity) begin
                        state_next = COMMIT;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
`endif
                default: state_next = IDLE;
            endcase
        end else if (state == COMMIT) begin
            state_next = IDLE;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            index <= '0;
            c     <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            index <= index_next;
            err   <= err_next;
            if (store) begin
                c[int'(store_idx) * IN_W +: IN_W] <= cfg_data;
            end
        end
    end

`ifdef SWITCH_BOX_CONFIG_LOADER_PARITY_EN
    // Running XOR of the frame; a start chunk restarts it from that chunk alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (store) begin
            parity <= (store_idx == '0) ? (^cfg_data) : (parity ^ (^cfg_data));
        end
    end
`endif

endmodule

// File: doc/switch_box_config_loader.md
Name: switch_box_config_loader

Overview:
- Upstream configuration stage for disjoint_switch_box.
- Accepts the configuration bitstream as IN_W-bit chunks over a valid/ready stream and assembles one CONF_WIDTH-bit frame.
- Presents the frame on c with a one-cycle cset pulse, which the switch box latches into its config register.
- One loader per switch box; the frame is the full 8-bits-per-track configuration word.

Parameters:
- W, 8: tracks per side of the fed switch box.
- CONF_WIDTH, 8*W: frame width; must equal the switch box CONF_WIDTH.
- IN_W, 8: chunk width. CONF_WIDTH % IN_W == 0 is required (elaboration error otherwise).
- NUM_CHUNKS, CONF_WIDTH/IN_W: derived; not for override.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  chunk valid.
- cfg_ready  out  1  loader can accept a chunk.
- cfg_data  in  IN_W  chunk payload.
- cfg_start  in  1  qualifies cfg_data as chunk 0 of a new frame.
- c  out  CONF_WIDTH  assembled frame; meaningful only while cset=1.
- cset  out  1  one-cycle commit strobe to the switch box.
- busy  out  1  frame in progress (state != IDLE).
- err  out  1  sticky error flag.

Behaviour:
- Reset: all registers reset synchronously; rst overrides all other inputs, including mid-frame (partial frame discarded, no cset).
  - State=IDLE, index=0, c=0, cset=0, err=0, busy=0.
  - cfg_ready=1 from the first cycle after rst deasserts.
- Handshake: a chunk is accepted on a rising edge where cfg_valid && cfg_ready. cfg_data and cfg_start are sampled only on accept.
- cfg_ready is combinational from state: 1 in IDLE/LOAD (and CHECK with macro), 0 in COMMIT.
- Chunk k of a frame is written to c[k*IN_W +: IN_W], so chunk 0 is the LSBs.
- States:
  - IDLE:
    - Accept with cfg_start=1 -> store chunk 0, index=1, go to LOAD. If NUM_CHUNKS==1, go straight to COMMIT (or CHECK with macro).
    - Accept with cfg_start=0 -> chunk discarded, err<=1, stay in IDLE.
  - LOAD:
    - Accept with cfg_start=0 -> store at index, index+1.
    - The accept storing index NUM_CHUNKS-1 -> COMMIT (or CHECK with macro), index=0.
    - Accept with cfg_start=1 -> resync: store as chunk 0, index=1, stay in LOAD. Earlier partial data is overwritten progressively; no error is raised.
  - COMMIT: cset=1 for exactly this one cycle, cfg_ready=0 -> IDLE next cycle.
- Latency: last chunk accepted at edge N; cset high between edges N and N+1; switch box captures at edge N+1. Minimum frame spacing is NUM_CHUNKS+1 cycles.
- c holds its value after COMMIT until overwritten by the next frame's chunks; c is never cleared except by rst.
- cset is registered (state decode of a flop), never combinational from inputs.
- err stays set until rst.

Optional Feature:
- Macro: SWITCH_BOX_CONFIG_LOADER_PARITY_EN.
- With the macro defined:
  - After the last data chunk the loader enters CHECK, where cfg_ready=1.
  - The next accepted chunk is a parity chunk. Bit 0 must equal the XOR of all CONF_WIDTH frame bits; upper bits are ignored.
  - Match -> COMMIT. Mismatch -> err<=1, IDLE, no cset.
  - Accept with cfg_start=1 in CHECK -> treated as a resync, exactly as in LOAD; no parity check is performed.
  - Running parity is maintained incrementally per chunk.
- Without the macro: no CHECK state, no parity logic; behaviour is exactly as in the Behaviour section.

Decomposition:
- Package switch_box_cfg_pkg holds:
  - the state enum (IDLE, LOAD, CHECK, COMMIT);
  - a clog2-based index-width function;
  - localparam CHUNK_PER_TRACK = 8/IN_W helper constants.
- No sub-module: the loader is a single FSM plus an index counter. The CHECK state exists only under the macro.

Test Plan (W=2, CONF_WIDTH=16, IN_W=8):
- Reset, then start chunk 0x34 followed by 0x12 (valid every cycle) -> cset high exactly one cycle after the second accept, c=16'h1234; cfg_ready=0 during that cycle; busy falls the cycle after cset.
- cfg_valid toggled 1,0,1 with gaps between chunks -> same c=16'h1234, cset delayed correspondingly; no extra cset pulses.
- Chunk 0xAA without cfg_start in IDLE -> err=1, no cset; a subsequent valid frame still commits while err stays 1.
- Start 0x11, then start 0x22 (resync), then 0x33 -> c=16'h3322, single cset pulse.
- rst asserted after chunk 0 of a frame -> no cset, c=0, err=0; a following full frame commits normally.
- With the macro: frame 0x01,0x00 plus parity 0x01 -> cset, c=16'h0001. Same frame with parity 0x00 -> err=1, no cset.
